// File: rtl/frog_collide.sv
// Frog movement, collision detection, lives and respawn control for the lane game.
// Consumes every lane's occupancy row and drives the shared hit line that freezes the lanes.
module frog_collide #(
  parameter int LANES     = 6,
  parameter int LIVES     = 3,
  parameter int RESPAWN   = 255,
  parameter int START_COL = 7
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        btn_up,
  input  logic                        btn_down,
  input  logic                        btn_left,
  input  logic                        btn_right,
  input  logic [LANES*16-1:0]         lane_rows,
  output logic [$clog2(LANES+2)-1:0]  frog_row,
  output logic [3:0]                  frog_col,
  output logic [1:0]                  lives,
  output logic                        dead,
  output logic                        win,
  output logic                        hit
);

  localparam int RW = $clog2(LANES + 2);
  localparam int CW = $clog2(RESPAWN + 1);

  typedef enum logic [1:0] {S_PLAY, S_DEAD, S_OVER, S_WIN} state_t;

  state_t          r_state;
  logic [3:0]      r_sync1;
  logic [3:0]      r_sync2;
  logic [3:0]      r_prev;
  logic [RW-1:0]   r_row;
  logic [3:0]      r_col;
  logic [1:0]      r_lives;
  logic [CW-1:0]   r_cnt;

  logic [3:0]      w_edge;
  logic [15:0]     w_row_bits;
  logic            w_coll;

  // Button vectors are packed {up, down, left, right}
  assign w_edge = r_sync2 & ~r_prev;

  // Rows 0 and LANES+1 select no lane, so they can never collide
  always_comb begin
    w_row_bits = '0;
    for (int unsigned r = 0; r < LANES; r++) begin
      if (r_row == RW'(r + 1)) w_row_bits = lane_rows[r*16 +: 16];
    end
  end

  assign w_coll = (r_state == S_PLAY) && w_row_bits[4'd15 - r_col];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_state <= S_PLAY;
      r_row   <= '0;
      r_col   <= 4'(START_COL);
      r_lives <= 2'(LIVES);
      r_cnt   <= '0;
    end else begin
      r_sync1 <= {btn_up, btn_down, btn_left, btn_right};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      case (r_state)
        S_PLAY: begin
          if (w_coll) begin
            if (r_lives > 2'd1) begin
              r_lives <= r_lives - 2'd1;
              r_state <= S_DEAD;
              r_cnt   <= CW'(RESPAWN - 1);
            end else begin
              r_lives <= '0;
              r_state <= S_OVER;
            end
          end else if (w_edge[3]) begin
            if (r_row == RW'(LANES)) begin
              r_row   <= RW'(LANES + 1);
              r_state <= S_WIN;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end else if (w_edge[2]) begin
            if (r_row != '0) r_row <= r_row - 1'b1;
          end else if (w_edge[1]) begin
            if (r_col != 4'd0) r_col <= r_col - 4'd1;
          end else if (w_edge[0]) begin
            if (r_col != 4'd15) r_col <= r_col + 4'd1;
          end
        end
        S_DEAD: begin
          if (r_cnt == '0) begin
            r_state <= S_PLAY;
            r_row   <= '0;
            r_col   <= 4'(START_COL);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign frog_row = r_row;
  assign frog_col = r_col;
  assign lives    = r_lives;
  assign dead     = (r_state == S_DEAD);
  assign win      = (r_state == S_WIN);
  assign hit      = (r_state == S_OVER);

endmodule

// File: tb/tb_frog_collide.sv
// Bench for frog_collide: history-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_frog_collide;

  localparam int LANES     = 6;
  localparam int LIVES     = 3;
  localparam int RESPAWN   = 5;
  localparam int START_COL = 7;
  localparam int RW        = $clog2(LANES + 2);

  localparam int M_PLAY = 0;
  localparam int M_DEAD = 1;
  localparam int M_OVER = 2;
  localparam int M_WIN  = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 btn_up = 1'b0;
  logic                 btn_down = 1'b0;
  logic                 btn_left = 1'b0;
  logic                 btn_right = 1'b0;
  logic [LANES*16-1:0]  lane_rows = '0;
  logic [RW-1:0]        frog_row;
  logic [3:0]           frog_col;
  logic [1:0]           lives;
  logic                 dead;
  logic                 win;
  logic                 hit;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  frog_collide #(
    .LANES(LANES),
    .LIVES(LIVES),
    .RESPAWN(RESPAWN),
    .START_COL(START_COL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .lane_rows(lane_rows),
    .frog_row(frog_row),
    .frog_col(frog_col),
    .lives(lives),
    .dead(dead),
    .win(win),
    .hit(hit)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: a move fires at edge n when the raw button sampled at
  // edge n-2 was high and at edge n-3 was low.
  int         m_row, m_col, m_lives, m_mode, m_dead_n;
  logic [3:0] hist[$];

  task automatic model_step();
    logic [3:0] e;
    bit         coll;
    if (reset) begin
      m_mode = M_PLAY; m_row = 0; m_col = START_COL; m_lives = LIVES; m_dead_n = 0;
      hist = '{4'b0, 4'b0, 4'b0, 4'b0};
      return;
    end
    hist.push_front({btn_up, btn_down, btn_left, btn_right});
    void'(hist.pop_back());
    e = hist[2] & ~hist[3];
    coll = (m_mode == M_PLAY) && (m_row >= 1) && (m_row <= LANES) &&
           lane_rows[(m_row - 1) * 16 + 15 - m_col];
    case (m_mode)
      M_PLAY: begin
        if (coll) begin
          if (m_lives > 1) begin m_lives--; m_mode = M_DEAD; m_dead_n = 0; end
          else begin m_lives = 0; m_mode = M_OVER; end
        end else if (e[3]) begin
          m_row++;
          if (m_row == LANES + 1) m_mode = M_WIN;
        end else if (e[2]) begin
          if (m_row > 0) m_row--;
        end else if (e[1]) begin
          if (m_col > 0) m_col--;
        end else if (e[0]) begin
          if (m_col < 15) m_col++;
        end
      end
      M_DEAD: begin
        m_dead_n++;
        if (m_dead_n == RESPAWN) begin m_mode = M_PLAY; m_row = 0; m_col = START_COL; end
      end
      default: ;
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("model_row",   int'(frog_row), m_row);
      chk("model_col",   int'(frog_col), m_col);
      chk("model_lives", int'(lives),    m_lives);
      chk("model_dead",  int'(dead),     int'(m_mode == M_DEAD));
      chk("model_win",   int'(win),      int'(m_mode == M_WIN));
      chk("model_hit",   int'(hit),      int'(m_mode == M_OVER));
    end
  end

  task automatic set_btn(input logic [3:0] m);
    {btn_up, btn_down, btn_left, btn_right} = m;
  endtask

  task automatic press(input logic [3:0] m);
    @(negedge clk); set_btn(m);
    @(negedge clk); set_btn(4'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); @(negedge clk); reset = 1'b0;
  endtask

  task automatic measure_dead(output int n);
    n = 0;
    while (dead && n < 50) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic chk_pos(input string name, input int r, input int c);
    chk({name, "_row"}, int'(frog_row), r);
    chk({name, "_col"}, int'(frog_col), c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_pos("rst", 0, 7);
    chk("rst_lives", int'(lives), 3);
    chk("rst_flags", int'({dead, win, hit}), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // single-cycle right press: move lands two edges after the sampling edge
    set_btn(4'b0001);
    @(posedge clk);
    @(negedge clk); set_btn(4'b0);
    @(posedge clk); #1; chk("lat_k1_col", int'(frog_col), 7);
    @(posedge clk); #1; chk("lat_k2_col", int'(frog_col), 8);

    // held right for 10 cycles gives exactly one move
    @(negedge clk); set_btn(4'b0001);
    repeat (10) @(negedge clk);
    set_btn(4'b0);
    repeat (3) @(negedge clk);
    chk("hold_col", int'(frog_col), 9);

    // collision in lane 1 at col 7, then respawn
    do_reset();
    press(4'b1000);
    chk_pos("lane1", 1, 7);
    @(negedge clk); lane_rows[8] = 1'b1;
    @(posedge clk); #1;
    chk("coll1_lives", int'(lives), 2);
    chk("coll1_dead", int'(dead), 1);
    measure_dead(n);
    chk("coll1_dead_len", n, RESPAWN);
    chk_pos("respawn", 0, 7);
    @(negedge clk); lane_rows = '0;

    // two more collisions exhaust the lives
    lane_rows[15:0] = 16'hFFFF;
    press(4'b1000);
    chk("coll2_lives", int'(lives), 1);
    chk("coll2_dead", int'(dead), 1);
    measure_dead(n);
    chk("coll2_dead_len", n, RESPAWN);
    press(4'b1000);
    chk("over_lives", int'(lives), 0);
    chk("over_hit", int'(hit), 1);
    press(4'b1000);
    press(4'b0001);
    chk_pos("over_frozen", 1, 7);
    chk("over_hit_hold", int'(hit), 1);
    @(negedge clk); lane_rows = '0;
    do_reset();
    chk("after_over_lives", int'(lives), 3);
    chk("after_over_hit", int'(hit), 0);

    // climb to the goal
    for (int i = 0; i < LANES + 1; i++) press(4'b1000);
    chk("win_row", int'(frog_row), 7);
    chk("win_flag", int'(win), 1);
    chk("win_hit", int'(hit), 0);
    press(4'b0100);
    chk("win_down_row", int'(frog_row), 7);
    do_reset();

    // clamping and same-cycle priority
    for (int i = 0; i < 7; i++) press(4'b0010);
    chk_pos("left_edge", 0, 0);
    press(4'b0110);
    chk_pos("clamp", 0, 0);
    press(4'b1001);
    chk_pos("up_right", 1, 0);

    // collision beats a simultaneous left move, then reset mid-DEAD
    press(4'b1000);
    for (int i = 0; i < 3; i++) press(4'b0001);
    chk_pos("lane2", 2, 3);
    @(negedge clk); set_btn(4'b0010);
    @(negedge clk); set_btn(4'b0);
    @(negedge clk); lane_rows[28] = 1'b1;
    @(posedge clk); #1;
    chk_pos("coll_vs_move", 2, 3);
    chk("coll_vs_move_lives", int'(lives), 2);
    chk("coll_vs_move_dead", int'(dead), 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_pos("mid_dead_rst", 0, 7);
    chk("mid_dead_rst_lives", int'(lives), 3);
    chk("mid_dead_rst_dead", int'(dead), 0);
    @(negedge clk); lane_rows = '0;
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
